// File: rtl/mem_image_writer_pkg.sv
// Shared definitions for the program-memory image writer and its read-side counterpart.
// Holds the record-parser state encodings, default sync marker and memory geometry.
// No logic; imported by the writer top.
package mem_image_writer_pkg;

  // Memory geometry, shared with the memory display/read path.
  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 8;

  // Default record start marker.
  localparam logic [7:0] SYNC_BYTE_DEF = 8'h55;

  // Record parser states, in stream order.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AHI  = 3'd1,
    ST_ALO  = 3'd2,
    ST_LEN  = 3'd3,
    ST_DATA = 3'd4,
    ST_CHK  = 3'd5
  } state_t;

endpackage

// File: rtl/mem_image_writer.sv
// Parses framed load records (SYNC, ADDR_HI, ADDR_LO, LEN, data x LEN, CHK) and writes payload to memory.
// Latency: data byte accepted at edge N -> mem_we/addr/wdata in cycle N+1; CHK -> rec_ok/rec_err in cycle N+1.
// Backpressure: none; rx_ready is high whenever out of reset, throughput one byte per clock.
//
// Ports:
//   Clock, Reset            - system clock (rising edge), asynchronous active-high reset
//   rx_data/rx_valid/rx_ready - incoming byte stream, accepted on rx_valid & rx_ready
//   mem_addr/mem_wdata/mem_we - memory write port, one-cycle strobe, addr/data hold when idle
//   busy                    - a record is in progress
//   rec_ok/rec_err          - one-cycle record completion pulses (checksum good / bad)
//   err_cnt                 - saturating count of bad-checksum records
//   byte_cnt                - wrapping count of payload bytes written
module mem_image_writer
  import mem_image_writer_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         ERR_CNT_W = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [MEM_DATA_W-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  busy,
  output logic                  rec_ok,
  output logic                  rec_err,
  output logic [ERR_CNT_W-1:0]  err_cnt,
  output logic [15:0]           byte_cnt
);

  state_t                state, state_nxt;
  logic                  accept;
  logic [7:0]            sum;       // running checksum, excludes the sync byte
  logic [7:0]            sum_nxt;
  logic [7:0]            remain;    // payload bytes still expected in DATA
  logic [MEM_ADDR_W-1:0] wr_ptr;    // next write address; mem_addr only follows it on a write

  assign accept  = rx_valid & rx_ready;
  assign sum_nxt = sum + rx_data;
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        ST_IDLE: if (rx_data == SYNC_BYTE) state_nxt = ST_AHI;
        ST_AHI:  state_nxt = ST_ALO;
        ST_ALO:  state_nxt = ST_LEN;
        ST_LEN:  state_nxt = (rx_data != 8'd0) ? ST_DATA : ST_CHK;
        ST_DATA: if (remain == 8'd1) state_nxt = ST_CHK;
        ST_CHK:  state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rx_ready  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      rec_ok    <= 1'b0;
      rec_err   <= 1'b0;
      err_cnt   <= '0;
      byte_cnt  <= '0;
      sum       <= '0;
      remain    <= '0;
      wr_ptr    <= '0;
    end else begin
      rx_ready <= 1'b1;
      mem_we   <= 1'b0;
      rec_ok   <= 1'b0;
      rec_err  <= 1'b0;
      if (accept) begin
        case (state)
          ST_IDLE: sum <= '0;
          ST_AHI: begin
            wr_ptr[15:8] <= rx_data;
            sum          <= rx_data;
          end
          ST_ALO: begin
            wr_ptr[7:0] <= rx_data;
            sum         <= sum_nxt;
          end
          ST_LEN: begin
            remain <= rx_data;
            sum    <= sum_nxt;
          end
          ST_DATA: begin
            // Written straight through; a later bad checksum does not roll this back.
            mem_we    <= 1'b1;
            mem_addr  <= wr_ptr;
            mem_wdata <= rx_data;
            wr_ptr    <= wr_ptr + 16'd1;
            remain    <= remain - 8'd1;
            byte_cnt  <= byte_cnt + 16'd1;
            sum       <= sum_nxt;
          end
          ST_CHK: begin
            if (sum_nxt == 8'd0) begin
              rec_ok <= 1'b1;
            end else begin
              rec_err <= 1'b1;
              if (err_cnt != {ERR_CNT_W{1'b1}})
                err_cnt <= err_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
            end
          end
          default: sum <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_image_writer.sv
// Self-checking bench for mem_image_writer: record table plus hand-written reset sequences,
// with a scoreboard of expected writes and record results checked as the DUT produces them.
module tb_mem_image_writer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        busy;
  logic        rec_ok;
  logic        rec_err;
  logic [7:0]  err_cnt;
  logic [15:0] byte_cnt;

  mem_image_writer #(.SYNC_BYTE(8'h55), .ERR_CNT_W(8)) dut (
    .Clock(Clock), .Reset(Reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .busy(busy), .rec_ok(rec_ok), .rec_err(rec_err), .err_cnt(err_cnt), .byte_cnt(byte_cnt)
  );

  always #5 Clock = ~Clock;

  longint cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int vec  = 0;
  int errs = 0;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic [15:0] bc;
    longint      stamp;
  } wr_t;

  typedef struct {
    bit         ok;
    logic [7:0] ec;
    longint     stamp;
  } res_t;

  wr_t  wq[$];
  res_t rq[$];

  // Bench-side model counters.
  logic [15:0] m_byte_cnt = 16'd0;
  logic [7:0]  m_err_cnt  = 8'd0;

  typedef struct {
    string      name;
    logic [7:0] b [0:7];
    int         n;
    bit         noise;
    bit         gaps;
    int         reps;
  } rec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard side: compare whatever the DUT produces against the queues.
  always @(negedge Clock) begin
    if (!Reset) begin
      if (mem_we) begin
        vec++;
        if (wq.size() == 0) begin
          errs++;
          $display("FAIL write: unexpected write addr %h data %h", mem_addr, mem_wdata);
        end else begin
          wr_t w;
          w = wq.pop_front();
          if (mem_addr !== w.a || mem_wdata !== w.d || byte_cnt !== w.bc || cyc != w.stamp) begin
            errs++;
            $display("FAIL write: got addr %h data %h bcnt %h cyc %0d expected addr %h data %h bcnt %h cyc %0d",
                     mem_addr, mem_wdata, byte_cnt, cyc, w.a, w.d, w.bc, w.stamp);
          end
        end
      end
      if (rec_ok || rec_err) begin
        vec++;
        if (rq.size() == 0) begin
          errs++;
          $display("FAIL result: unexpected pulse ok %b err %b", rec_ok, rec_err);
        end else begin
          res_t r;
          r = rq.pop_front();
          if (rec_ok !== r.ok || rec_err !== !r.ok || err_cnt !== r.ec || busy !== 1'b0 || cyc != r.stamp) begin
            errs++;
            $display("FAIL result: got ok %b err %b ecnt %h busy %b cyc %0d expected ok %b ecnt %h cyc %0d",
                     rec_ok, rec_err, err_cnt, busy, cyc, r.ok, r.ec, r.stamp);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) begin
      @(posedge Clock); #1;
    end
  endtask

  // Drives one byte for exactly one accepted edge; optionally inserts random idle cycles first.
  task automatic send_byte(input logic [7:0] b, input bit gaps, output longint stamp);
    while (gaps && $urandom_range(0, 2) == 0) begin
      rx_valid = 1'b0;
      @(posedge Clock); #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    stamp    = cyc + 1;
    @(posedge Clock); #1;
  endtask

  task automatic send_record(input rec_t r);
    longint     st;
    logic [15:0] ptr;
    logic [7:0]  len, sum;
    wr_t         w;
    res_t        rs;
    if (r.noise) begin
      send_byte(8'h00, r.gaps, st);
      send_byte(8'hFF, r.gaps, st);
      send_byte(8'h3C, r.gaps, st);
    end
    ptr = {r.b[1], r.b[2]};
    len = r.b[3];
    sum = 8'h00;
    for (int i = 0; i < r.n; i++) begin
      send_byte(r.b[i], r.gaps, st);
      if (i >= 1) sum = sum + r.b[i];
      if (i >= 4 && i < 4 + int'(len)) begin
        m_byte_cnt = m_byte_cnt + 16'd1;
        w.a = ptr; w.d = r.b[i]; w.bc = m_byte_cnt; w.stamp = st;
        wq.push_back(w);
        ptr = ptr + 16'd1;
      end
      if (i == r.n - 1) begin
        rs.ok = (sum == 8'h00);
        if (!rs.ok && m_err_cnt != 8'hFF) m_err_cnt = m_err_cnt + 8'd1;
        rs.ec = m_err_cnt; rs.stamp = st;
        rq.push_back(rs);
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " rx_ready"}, {31'd0, rx_ready}, 32'd0);
    check({tag, " mem_addr"}, {16'd0, mem_addr}, 32'd0);
    check({tag, " mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
    check({tag, " mem_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, " busy"}, {31'd0, busy}, 32'd0);
    check({tag, " rec_ok/err"}, {30'd0, rec_ok, rec_err}, 32'd0);
    check({tag, " err_cnt"}, {24'd0, err_cnt}, 32'd0);
    check({tag, " byte_cnt"}, {16'd0, byte_cnt}, 32'd0);
  endtask

  rec_t tbl[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint st;
    tbl[0] = '{"good",     '{8'h55,8'h12,8'h34,8'h02,8'hAB,8'hCD,8'h40,8'h00}, 7, 0, 0, 1};
    tbl[1] = '{"wrap",     '{8'h55,8'hFF,8'hFF,8'h02,8'h11,8'h22,8'hCD,8'h00}, 7, 0, 0, 1};
    tbl[2] = '{"empty",    '{8'h55,8'h00,8'h10,8'h00,8'hF0,8'h00,8'h00,8'h00}, 5, 0, 0, 1};
    tbl[3] = '{"syncdata", '{8'h55,8'h00,8'h00,8'h01,8'h55,8'hAA,8'h00,8'h00}, 6, 0, 0, 1};
    tbl[4] = '{"badchk",   '{8'h55,8'h12,8'h34,8'h02,8'hAB,8'hCD,8'h41,8'h00}, 7, 0, 0, 300};
    tbl[5] = '{"noisegap", '{8'h55,8'h12,8'h34,8'h02,8'hAB,8'hCD,8'h40,8'h00}, 7, 1, 1, 1};

    Reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #3;
    check_reset_values("por");
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(posedge Clock); #1;
    check("rx_ready after reset", {31'd0, rx_ready}, 32'd1);

    // Table-driven records.
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < tbl[t].reps; k++) send_record(tbl[t]);
      idle(3);
      check({tbl[t].name, " byte_cnt"}, {16'd0, byte_cnt}, {16'd0, m_byte_cnt});
      check({tbl[t].name, " err_cnt"}, {24'd0, err_cnt}, {24'd0, m_err_cnt});
      check({tbl[t].name, " busy"}, {31'd0, busy}, 32'd0);
    end
    check("err_cnt saturated", {24'd0, err_cnt}, 32'd255);

    // Busy during a record, then reset mid-record: no writes, no pulse.
    send_byte(8'h55, 0, st);
    send_byte(8'h12, 0, st);
    send_byte(8'h34, 0, st);
    rx_valid = 1'b0;
    check("busy mid-record", {31'd0, busy}, 32'd1);
    Reset = 1'b1;
    #2;
    check_reset_values("midrec");
    m_byte_cnt = 16'd0;
    m_err_cnt  = 8'd0;
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    check("rx_ready held low", {31'd0, rx_ready}, 32'd0);
    @(posedge Clock); #1;
    check("rx_ready after midrec", {31'd0, rx_ready}, 32'd1);
    send_record(tbl[0]);
    idle(3);
    check("post-reset byte_cnt", {16'd0, byte_cnt}, 32'd2);
    check("post-reset err_cnt", {24'd0, err_cnt}, 32'd0);
    check("post-reset addr hold", {8'd0, mem_addr, mem_wdata}, {8'd0, 16'h1235, 8'hCD});

    idle(2);
    check("writes pending", wq.size(), 32'd0);
    check("results pending", rq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
